// File: rtl/report_uart_tx.sv
// report_uart_tx -- reporting stage for the PSK correlator dispatcher.
//
// Captures each {metric, offset} pair presented on value/rdy (metric on the
// rdy rising-edge cycle, offset on the following cycle), queues it in a
// small record FIFO and sends it to the host as an 8N1 UART packet:
//   0xA5, offset, metric [, checksum]
// Records arriving while the FIFO is full are dropped and counted.
//
// Optional feature: define REPORT_CHECKSUM_EN to append a fourth byte
// (0xA5 ^ offset ^ metric) to every packet. Undefined: three-byte packets.
//
// Parameters:
//   CLK_DIV   clock cycles per UART bit (2..65535)
//   FIFO_AW   record FIFO address width, depth = 2**FIFO_AW (>= 1)
// Ports:
//   clk       system clock, rising edge
//   rst_in    synchronous active-high reset
//   value     dispatcher data byte
//   rdy       dispatcher ready level (rising edge starts a capture)
//   tx        UART line, idle high, registered
//   busy      packet in flight or FIFO non-empty
//   drop_cnt  saturating count of dropped records

module report_uart_tx #(
  parameter int CLK_DIV = 104,
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst_in,
  input  logic [7:0] value,
  input  logic       rdy,
  output logic       tx,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  localparam int          DEPTH    = 1 << FIFO_AW;
  localparam logic [15:0] BIT_LAST = 16'(CLK_DIV - 1);
  localparam logic [7:0]  HEADER   = 8'hA5;
`ifdef REPORT_CHECKSUM_EN
  localparam logic [1:0]  LAST_BYTE = 2'd3;
`else
  localparam logic [1:0]  LAST_BYTE = 2'd2;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

  // ---------------------------------------------------------------- capture
  logic       r_rdy_d;
  logic       r_armed;     // set once rdy has been seen low after reset
  logic       r_cap_pend;  // high on the cycle after an accepted edge
  logic [7:0] r_metric;
  logic       w_rdy_rise;
  logic       w_push;

  // r_armed blocks a level rdy that was already high across reset from
  // looking like a fresh rising edge.
  assign w_rdy_rise = rdy & ~r_rdy_d & r_armed;
  assign w_push     = r_cap_pend;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_rdy_d    <= 1'b0;
      r_armed    <= 1'b0;
      r_cap_pend <= 1'b0;
      r_metric   <= '0;
    end else begin
      r_rdy_d    <= rdy;
      r_cap_pend <= w_rdy_rise;
      if (!rdy)       r_armed  <= 1'b1;
      if (w_rdy_rise) r_metric <= value;
    end
  end

  // ------------------------------------------------------------------- FIFO
  logic [15:0]      r_mem [DEPTH];
  logic [FIFO_AW:0] r_wr_ptr;
  logic [FIFO_AW:0] r_rd_ptr;
  logic [7:0]       r_drop_cnt;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_accept;
  logic [15:0]      w_head;

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                    (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  // A same-cycle pop frees a slot, so push+pop while full is accepted.
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_head   = r_mem[r_rd_ptr[FIFO_AW-1:0]];

  // NOTE: the storage array has no reset; only the pointers define validity,
  // which keeps it mappable to plain RAM/flops without reset muxes.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= {value, r_metric};
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_accept && r_drop_cnt != 8'hFF)
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------- UART TX
  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_tx;
  logic        w_tx_nxt;
  logic [15:0] r_timer;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_idx;
  logic [1:0]  r_byte_idx;
  logic [15:0] r_rec;        // {offset, metric} of the packet in flight
  logic [7:0]  w_next_byte;  // byte that follows r_byte_idx in the packet
  logic        w_bit_end;

  assign w_bit_end = (r_state == S_START || r_state == S_DATA ||
                      r_state == S_STOP) && (r_timer == BIT_LAST);

  always_comb begin
    w_next_byte = HEADER;
    case (r_byte_idx)
      2'd0:    w_next_byte = r_rec[15:8];
      2'd1:    w_next_byte = r_rec[7:0];
`ifdef REPORT_CHECKSUM_EN
      2'd2:    w_next_byte = HEADER ^ r_rec[15:8] ^ r_rec[7:0];
`endif
      default: w_next_byte = HEADER;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        // Looking at the incoming push lets LOAD follow the write cycle
        // directly when the queue was empty.
        if (!w_empty || w_push) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_pop       = ~w_empty;
        w_tx_nxt    = 1'b0;
        w_state_nxt = S_START;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_tx_nxt = r_shift[1];  // bit about to become r_shift[0]
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_byte_idx == LAST_BYTE) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_timer    <= '0;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_rec      <= '0;
    end else begin
      if (r_state == S_IDLE || r_state == S_LOAD || w_bit_end) r_timer <= '0;
      else                                                     r_timer <= r_timer + 16'd1;
      case (r_state)
        S_LOAD: begin
          r_rec      <= w_head;
          r_shift    <= HEADER;
          r_bit_idx  <= '0;
          r_byte_idx <= '0;
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 3'd1;  // wraps to 0 after bit 7
          end
        end
        S_STOP: begin
          if (w_bit_end && r_byte_idx != LAST_BYTE) begin
            r_shift    <= w_next_byte;
            r_byte_idx <= r_byte_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx       = r_tx;
  assign busy     = (r_state != S_IDLE) | ~w_empty;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_report_uart_tx.sv
// tb_report_uart_tx -- directed self-checking bench for report_uart_tx
// (CLK_DIV=4, FIFO_AW=2). A UART decoder samples tx on falling edges and
// queues decoded bytes with their start cycle and a framing flag.

module tb_report_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int BIT_CYC = 10 * CLK_DIV;
`ifdef REPORT_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic       clk;
  logic       rst_in;
  logic [7:0] value;
  logic       rdy;
  logic       tx;
  logic       busy;
  logic [7:0] drop_cnt;

  int n_chk = 0;
  int n_err = 0;

  report_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(2)) dut (
    .clk     (clk),
    .rst_in  (rst_in),
    .value   (value),
    .rdy     (rdy),
    .tx      (tx),
    .busy    (busy),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------- decoder
  int unsigned cyc = 0;
  logic        rst_q = 1'b1;
  logic        dec_act = 1'b0;
  int          dec_k;
  int unsigned dec_start;
  logic [39:0] smp;
  logic [7:0]  rx_q[$];
  int unsigned rx_t[$];
  logic        rx_ok[$];

  always @(posedge clk) rst_q <= rst_in;

  always @(negedge clk) begin
    logic       ok;
    logic [7:0] b;
    cyc++;
    if (rst_q) begin
      dec_act = 1'b0;
    end else if (!dec_act) begin
      if (tx === 1'b0) begin
        dec_act   = 1'b1;
        dec_start = cyc;
        smp       = '0;
        smp[0]    = tx;
        dec_k     = 1;
      end
    end else begin
      smp[dec_k] = tx;
      dec_k++;
      if (dec_k == BIT_CYC) begin
        ok = 1'b1;
        for (int j = 0; j < 10; j++)
          for (int s = 0; s < CLK_DIV; s++)
            if (smp[j*CLK_DIV+s] !== smp[j*CLK_DIV+2]) ok = 1'b0;
        if (smp[2] !== 1'b0 || smp[9*CLK_DIV+2] !== 1'b1) ok = 1'b0;
        for (int i = 0; i < 8; i++) b[i] = smp[(i+1)*CLK_DIV+2];
        rx_q.push_back(b);
        rx_t.push_back(dec_start);
        rx_ok.push_back(ok);
        dec_act = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------- helpers
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [7:0] off,
                                          input logic [7:0] met);
    case (i)
      0:       return 8'hA5;
      1:       return off;
      2:       return met;
      default: return 8'hA5 ^ off ^ met;
    endcase
  endfunction

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
    rx_ok.delete();
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    if (rx_q.size() < n) check("timeout", rx_q.size(), n);
  endtask

  task automatic check_pkt(input string tag, input int base,
                           input logic [7:0] off, input logic [7:0] met);
    for (int i = 0; i < NB; i++) begin
      check({tag, "_byte"}, rx_q[base+i], exp_byte(i, off, met));
      check({tag, "_frame"}, rx_ok[base+i], 1'b1);
      if (i > 0) check({tag, "_spacing"}, rx_t[base+i] - rx_t[base+i-1], BIT_CYC);
    end
  endtask

  task automatic send_rec(input logic [7:0] m, input logic [7:0] o);
    @(negedge clk); rdy = 1'b1; value = m;
    @(negedge clk); value = o;
    @(negedge clk); rdy = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    int n_low;
    int n_busy;
    int gap;

    rst_in = 1'b1;
    rdy    = 1'b0;
    value  = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop_cnt, 8'd0);
    rst_in = 1'b0;
    idle_cycles(3);
    clear_rx();

    // Single record: start bit exactly two edges after the sampling edge.
    @(negedge clk); rdy = 1'b1; value = 8'h3C;
    @(posedge clk); #1;
    check("t1_tx_n", tx, 1'b1);
    @(negedge clk); value = 8'h11;
    @(posedge clk); #1;
    check("t1_tx_n1", tx, 1'b1);
    check("t1_busy", busy, 1'b1);
    @(negedge clk); rdy = 1'b0;
    @(posedge clk); #1;
    check("t1_start", tx, 1'b0);
    wait_bytes(NB, NB * BIT_CYC + 50);
    check_pkt("t1", 0, 8'h11, 8'h3C);
    check("t1_duration", rx_t[NB-1] + BIT_CYC - rx_t[0], NB * BIT_CYC);
    check("t1_busy_end", busy, 1'b0);
    check("t1_tx_end", tx, 1'b1);
    idle_cycles(10);
    clear_rx();

    // Back-to-back records during one packet.
    for (int k = 0; k < 4; k++) send_rec(8'(k + 1), 8'(k + 10));
    wait_bytes(4 * NB, 4 * (NB * BIT_CYC + 10) + 100);
    for (int k = 0; k < 4; k++) check_pkt("t2", k * NB, 8'(k + 10), 8'(k + 1));
    for (int k = 1; k < 4; k++) begin
      gap = int'(rx_t[k*NB]) - int'(rx_t[k*NB-1]) - BIT_CYC;
      check("t2_gap", (gap >= 2), 1'b1);
    end
    check("t2_drop", drop_cnt, 8'd0);
    idle_cycles(20);
    clear_rx();

    // Overflow: 1 in flight + 4 queued, records 6 and 7 dropped.
    for (int k = 0; k < 7; k++) send_rec(8'(8'h20 + k), 8'(8'h60 + k));
    check("t3_drop", drop_cnt, 8'd2);
    wait_bytes(5 * NB, 5 * (NB * BIT_CYC + 10) + 100);
    for (int k = 0; k < 5; k++) check_pkt("t3", k * NB, 8'(8'h60 + k), 8'(8'h20 + k));
    idle_cycles(300);
    check("t3_no_extra", rx_q.size(), 5 * NB);
    check("t3_busy", busy, 1'b0);
    clear_rx();

    // Saturation: far more than 255 dropped records.
    for (int k = 0; k < 300; k++) send_rec(8'(k), 8'(k + 1));
    check("t4_sat", drop_cnt, 8'hFF);
    send_rec(8'h00, 8'h00);
    check("t4_sat_hold", drop_cnt, 8'hFF);
    @(negedge clk); rst_in = 1'b1;
    @(posedge clk); #1;
    check("t4_rst_drop", drop_cnt, 8'd0);
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_tx", tx, 1'b1);
    @(negedge clk); rst_in = 1'b0;
    idle_cycles(5);
    clear_rx();

    // Reset during the data bits of the offset byte, two records queued.
    for (int k = 0; k < 3; k++) send_rec(8'(8'h70 + k), 8'(8'h80 + k));
    wait_bytes(1, BIT_CYC + 50);
    idle_cycles(6);
    rst_in = 1'b1;
    @(posedge clk); #1;
    check("t5_tx", tx, 1'b1);
    check("t5_busy", busy, 1'b0);
    @(negedge clk); rst_in = 1'b0;
    n_low  = 0;
    n_busy = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) n_low++;
      if (busy !== 1'b0) n_busy++;
    end
    check("t5_tx_quiet", n_low, 0);
    check("t5_busy_quiet", n_busy, 0);
    check("t5_bytes", rx_q.size(), 1);
    clear_rx();

    // rdy held high across reset release: no capture.
    @(negedge clk); rst_in = 1'b1; rdy = 1'b1; value = 8'h55;
    @(negedge clk); rst_in = 1'b0;
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) n_busy++;
    end
    check("t6_no_capture", n_busy, 0);
    rdy = 1'b0;

    // Level rdy for 50 cycles: one packet from the edge and next cycle.
    @(negedge clk); rdy = 1'b1;
    for (int i = 0; i < 50; i++) begin
      value = 8'(8'h40 + i);
      @(negedge clk);
    end
    rdy = 1'b0;
    wait_bytes(NB, NB * BIT_CYC + 100);
    check_pkt("t6", 0, 8'h41, 8'h40);
    idle_cycles(200);
    check("t6_one_pkt", rx_q.size(), NB);
    check("t6_drop", drop_cnt, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
